// File: rtl/instr_decode_stage_pkg.sv
// Shared definitions for the decode stage: widths, instruction field
// positions, opcode values, FSM states and the queued entry layout.
package instr_decode_stage_pkg;
  localparam int IW = 18;
  localparam int AW = 8;

  localparam int OP_HI  = 17;
  localparam int OP_LO  = 14;
  localparam int RD_HI  = 13;
  localparam int RD_LO  = 11;
  localparam int RS_HI  = 10;
  localparam int RS_LO  = 8;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_LDI  = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_BEQ  = 4'h9;
  localparam logic [3:0] OP_BNE  = 4'hA;
  localparam logic [3:0] OP_ADDI = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_e;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } entry_t;
endpackage

// File: rtl/instr_decode_stage_if.sv
// Fetch-side and execute-side signals of the decode stage.
//   slave  : view of the decode stage (takes fetch data, drives decode results)
//   master : view of the surrounding pipeline / testbench
interface instr_decode_stage_if;
  import instr_decode_stage_pkg::*;
  logic          in_valid;
  logic [IW-1:0] in_instr;
  logic [AW-1:0] in_pc;
  logic          in_ready;
  logic          flush;
  logic          out_ready;
  logic          out_valid;
  logic [AW-1:0] out_pc;
  logic [3:0]    out_opcode;
  logic [2:0]    out_rd;
  logic [2:0]    out_rs;
  logic [7:0]    out_imm;
  logic          out_reg_we;
  logic          out_mem_rd;
  logic          out_mem_wr;
  logic          out_branch;
  logic          out_halt;
  logic          out_illegal;
  logic          halted;

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs, out_imm,
           out_reg_we, out_mem_rd, out_mem_wr, out_branch, out_halt,
           out_illegal, halted
  );
  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs, out_imm,
           out_reg_we, out_mem_rd, out_mem_wr, out_branch, out_halt,
           out_illegal, halted
  );
endinterface

// File: rtl/instr_queue.sv
// DEPTH-entry FIFO of {pc, instr}. push/pop must already be qualified by
// the caller; flush empties the queue and overrides push/pop.
// Ports: clk, reset (async low), push, pop, flush, wdata, rdata (head),
// full, empty.
module instr_queue
  import instr_decode_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  logic   pop,
  input  logic   flush,
  input  entry_t wdata,
  output entry_t rdata,
  output logic   full,
  output logic   empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // Slots are cleared on reset so an unwritten slot never holds X.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;   // DEPTH is a power of two: wraps
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/instr_decode_stage.sv
// Decode stage behind fetch: buffers instructions in a small queue, decodes
// the head into fields/control flags, and stops intake after HALT.
// Ports: clk, reset (async low), bus (instr_decode_stage_if.slave) carrying
// the fetch handshake, flush, execute handshake, decode outputs and halted.
module instr_decode_stage
  import instr_decode_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input logic                 clk,
  input logic                 reset,
  instr_decode_stage_if.slave bus
);
  state_e     state, state_nxt;
  entry_t     head;
  logic       full, empty, push, pop;
  logic [3:0] op;

  // in_ready depends only on registered state, never on out_ready.
  assign bus.in_ready  = !full && (state == RUN);
  assign bus.out_valid = !empty && (state != HALTED);
  assign bus.halted    = (state == HALTED);

  assign push = bus.in_valid && bus.in_ready && !bus.flush;
  assign pop  = bus.out_valid && bus.out_ready && !bus.flush;

  instr_queue #(.DEPTH(DEPTH)) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (bus.flush),
    .wdata ('{pc: bus.in_pc, instr: bus.in_instr}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_nxt;
  end

  // Only one HALT can ever be queued: intake stops the cycle after it.
  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = RUN;
    end else begin
      case (state)
        RUN:     if (push && bus.in_instr[OP_HI:OP_LO] == OP_HALT) state_nxt = DRAIN;
        DRAIN:   if (pop && op == OP_HALT) state_nxt = HALTED;
        default: state_nxt = state;
      endcase
    end
  end

  assign op = head.instr[OP_HI:OP_LO];

  always_comb begin
    bus.out_pc      = '0;
    bus.out_opcode  = '0;
    bus.out_rd      = '0;
    bus.out_rs      = '0;
    bus.out_imm     = '0;
    bus.out_reg_we  = 1'b0;
    bus.out_mem_rd  = 1'b0;
    bus.out_mem_wr  = 1'b0;
    bus.out_branch  = 1'b0;
    bus.out_halt    = 1'b0;
    bus.out_illegal = 1'b0;
    if (bus.out_valid) begin
      bus.out_pc     = head.pc;
      bus.out_opcode = op;
      bus.out_rd     = head.instr[RD_HI:RD_LO];
      bus.out_rs     = head.instr[RS_HI:RS_LO];
      bus.out_imm    = head.instr[IMM_HI:IMM_LO];
      case (op)
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LDI, OP_ADDI: bus.out_reg_we = 1'b1;
        OP_LD:  begin bus.out_reg_we = 1'b1; bus.out_mem_rd = 1'b1; end
        OP_ST:  bus.out_mem_wr = 1'b1;
        OP_JMP, OP_BEQ, OP_BNE: bus.out_branch = 1'b1;
        OP_HALT: bus.out_halt = 1'b1;
        4'hC, 4'hD, 4'hE: bus.out_illegal = 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_decode_stage.sv
module tb_instr_decode_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  instr_decode_stage_if bus ();
  instr_decode_stage #(.DEPTH(2)) dut (.clk(clk), .reset(rst_n), .bus(bus));

  typedef struct {
    logic [7:0]  pc;
    logic [17:0] instr;
  } ment_t;

  // Reference model: a plain list of buffered instructions plus two flags.
  ment_t mq[$];
  bit    m_stop;     // HALT accepted, no more intake
  bit    m_halted;   // HALT consumed

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_stop   = 0;
      m_halted = 0;
    end else if (bus.flush) begin
      mq.delete();
      m_stop   = 0;
      m_halted = 0;
    end else begin
      bit    can_pop, can_push;
      ment_t e;
      can_pop  = mq.size() > 0 && !m_halted && bus.out_ready;
      can_push = mq.size() < 2 && !m_stop && !m_halted && bus.in_valid;
      if (can_pop) begin
        e = mq.pop_front();
        if (e.instr[17:14] == 4'hF) begin m_halted = 1; m_stop = 0; end
      end
      if (can_push) begin
        e.pc = bus.in_pc; e.instr = bus.in_instr;
        mq.push_back(e);
        if (e.instr[17:14] == 4'hF) m_stop = 1;
      end
    end
  end

  // Compare process: every cycle after reset release, away from the edge.
  always @(negedge clk) if (rst_n) begin
    bit          ev;
    logic [17:0] hi;
    logic [7:0]  hp;
    logic [3:0]  op;
    ev = mq.size() > 0 && !m_halted;
    hi = ev ? mq[0].instr : 18'h0;
    hp = ev ? mq[0].pc : 8'h0;
    op = hi[17:14];
    chk("in_ready",  32'(bus.in_ready),  32'(mq.size() < 2 && !m_stop && !m_halted));
    chk("out_valid", 32'(bus.out_valid), 32'(ev));
    chk("halted",    32'(bus.halted),    32'(m_halted));
    chk("out_pc",    32'(bus.out_pc),    32'(hp));
    chk("opcode",    32'(bus.out_opcode), 32'(op));
    chk("rd",        32'(bus.out_rd),    32'(hi[13:11]));
    chk("rs",        32'(bus.out_rs),    32'(hi[10:8]));
    chk("imm",       32'(bus.out_imm),   32'(hi[7:0]));
    chk("reg_we",    32'(bus.out_reg_we), 32'(ev && op inside {4'h1,4'h2,4'h3,4'h4,4'h5,4'h6,4'hB}));
    chk("mem_rd",    32'(bus.out_mem_rd), 32'(ev && op == 4'h6));
    chk("mem_wr",    32'(bus.out_mem_wr), 32'(ev && op == 4'h7));
    chk("branch",    32'(bus.out_branch), 32'(ev && op inside {4'h8,4'h9,4'hA}));
    chk("halt",      32'(bus.out_halt),   32'(ev && op == 4'hF));
    chk("illegal",   32'(bus.out_illegal), 32'(ev && op inside {4'hC,4'hD,4'hE}));
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [17:0] ins, input logic [7:0] pc, input logic rdy);
    bus.in_valid = v; bus.in_instr = ins; bus.in_pc = pc; bus.out_ready = rdy;
  endtask

  initial begin
    drive(0, '0, '0, 0);
    bus.flush = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_halted", 32'(bus.halted), 0);
    chk("rst_reg_we", 32'(bus.out_reg_we), 0);

    // single ADD
    drive(1, 18'h04A05, 8'h00, 0); step();
    drive(0, '0, '0, 0);
    chk("add_valid", 32'(bus.out_valid), 1);
    chk("add_opcode", 32'(bus.out_opcode), 1);
    chk("add_rd", 32'(bus.out_rd), 1);
    chk("add_rs", 32'(bus.out_rs), 2);
    chk("add_imm", 32'(bus.out_imm), 5);
    chk("add_reg_we", 32'(bus.out_reg_we), 1);
    bus.out_ready = 1; step(); bus.out_ready = 0;
    chk("add_popped", 32'(bus.out_valid), 0);

    // back-pressure
    drive(1, 18'h04A05, 8'h00, 0); step();
    drive(1, 18'h08A05, 8'h01, 0); step();
    chk("bp_full", 32'(bus.in_ready), 0);
    drive(1, 18'h0CA05, 8'h02, 0); step();
    chk("bp_still_full", 32'(bus.in_ready), 0);
    drive(0, '0, '0, 1);
    chk("bp_first", 32'(bus.out_pc), 0);
    step();
    chk("bp_second", 32'(bus.out_pc), 1);
    step();
    chk("bp_empty", 32'(bus.out_valid), 0);
    chk("bp_ready", 32'(bus.in_ready), 1);

    // streaming with pointer wrap
    for (int i = 0; i < 10; i++) begin
      if (i > 0) chk("stream_pc", 32'(bus.out_pc), 32'(i - 1));
      drive(1, {4'h1, 14'($urandom)}, 8'(i), 1); step();
    end
    drive(0, '0, '0, 1); step();

    // HALT drain
    drive(1, 18'h14123, 8'h03, 0); step();
    drive(1, 18'h3C000, 8'h04, 0); step();
    chk("halt_no_intake", 32'(bus.in_ready), 0);
    drive(0, '0, '0, 1);
    chk("halt_ldi_pc", 32'(bus.out_pc), 3);
    step();
    chk("halt_pc", 32'(bus.out_pc), 4);
    chk("halt_flag", 32'(bus.out_halt), 1);
    step();
    chk("halted", 32'(bus.halted), 1);
    chk("halted_ov", 32'(bus.out_valid), 0);
    bus.out_ready = 0; bus.flush = 1; step(); bus.flush = 0;
    chk("unhalt", 32'(bus.halted), 0);
    chk("unhalt_ready", 32'(bus.in_ready), 1);

    // flush priority, then illegal opcode
    drive(1, 18'h04A05, 8'h10, 0); step();
    drive(1, 18'h04A05, 8'h11, 0); step();
    drive(1, 18'h04A05, 8'h12, 1); bus.flush = 1; step(); bus.flush = 0;
    drive(0, '0, '0, 0);
    chk("flush_ov", 32'(bus.out_valid), 0);
    chk("flush_ready", 32'(bus.in_ready), 1);
    drive(1, 18'h35ABC, 8'h20, 0); step();
    drive(0, '0, '0, 0);
    chk("illegal_flag", 32'(bus.out_illegal), 1);
    chk("illegal_we", 32'(bus.out_reg_we), 0);
    bus.out_ready = 1; step();

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 18'($urandom), 8'($urandom),
            1'($urandom_range(0, 2) != 0));
      bus.flush = ($urandom_range(0, 19) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/instr_decode_stage.md
Name: instr_decode_stage

Overview:
- Sits directly downstream of the fetch unit.
- Accepts the 18-bit instruction and its 8-bit PC through a valid/ready handshake, buffers them in a 2-entry queue and decodes the queue head into fields and control flags for execute.
- Back-pressures fetch, supports pipeline flush, and stops intake after a HALT instruction.

Parameters:
- IW, 18, instruction width
- AW, 8, PC/address width
- DEPTH, 2, queue entries (power of two, ≥2)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  fetch presents an instruction
- in_instr  in  IW  instruction word
- in_pc  in  AW  PC of in_instr
- in_ready  out  1  stage can accept this cycle
- flush  in  1  synchronous discard of all buffered instructions
- out_ready  in  1  execute consumes the head this cycle
- out_valid  out  1  head entry valid
- out_pc  out  AW  PC of the head entry
- out_opcode  out  4  instr[17:14]
- out_rd  out  3  instr[13:11]
- out_rs  out  3  instr[10:8]
- out_imm  out  8  instr[7:0]
- out_reg_we  out  1  opcode in {1,2,3,4,5,6,B}
- out_mem_rd  out  1  opcode 6 (LD)
- out_mem_wr  out  1  opcode 7 (ST)
- out_branch  out  1  opcode in {8,9,A} (JMP, BEQ, BNE)
- out_halt  out  1  opcode F
- out_illegal  out  1  opcode in {C,D,E}
- halted  out  1  state == HALTED

Behaviour:
- Opcode map:
  - 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 LDI
  - 6 LD, 7 ST, 8 JMP, 9 BEQ, A BNE, B ADDI
  - C–E illegal, F HALT
- Decode rules:
  - All decode outputs are a combinational function of the head entry only.
  - When out_valid=0 they are all 0.
- Reset (reset=0, asynchronous):
  - Queue empty, count=0, read/write pointers 0, state=RUN.
  - in_ready=1 as soon as reset is released; out_valid=0; all decode outputs 0; halted=0.
- Push: occurs when in_valid && in_ready at a rising edge. The entry is visible at the head on the next cycle, so first-instruction latency is 1 cycle.
- Pop: occurs when out_valid && out_ready at a rising edge.
- Simultaneous push and pop: count is unchanged and both pointers advance, wrapping modulo DEPTH.
- in_ready = (count < DEPTH) && state==RUN.
  - No combinational path from out_ready to in_ready.
  - A full queue refuses a push even if a pop happens in the same cycle.
- Empty queue: out_valid=0, and out_ready is ignored.
- State machine:
  - RUN → DRAIN when the pushed instruction has opcode F. in_ready=0 from the next cycle.
  - DRAIN → HALTED when the HALT entry is popped. Entries ahead of it drain normally.
  - HALTED: in_ready=0, out_valid=0, halted=1. Exit only by flush or reset.
- flush=1 at a rising edge:
  - Empties the queue, sets count=0, state=RUN.
  - A push or pop in the same cycle is ignored, so flush wins.
  - in_ready=1 on the next cycle.
- Illegal opcodes are queued and presented with out_illegal=1 and all other control flags 0. The stage does not trap.
- No X propagation: unused queue slots are never observed at the outputs.

Decomposition:
- Shared package: IW, AW, field bit positions, 4-bit opcode localparams (OP_NOP … OP_HALT), state encoding (RUN, DRAIN, HALTED).
- One natural sub-module, instr_queue: a parameterised DEPTH-entry FIFO holding {pc, instr}, with push/pop/flush, count, full/empty.
- Decode logic and the state machine stay in instr_decode_stage.

Test Plan:
- Reset check: hold reset=0, then release → in_ready=1, out_valid=0, halted=0, decode outputs 0.
- Single instruction: push instr=18'h0_4A05 (ADD rd=1, rs=2, imm=05), pc=8'h00 → next cycle out_valid=1, out_opcode=1, out_rd=1, out_rs=2, out_imm=05, out_reg_we=1; pop → out_valid=0.
- Back-pressure:
  - With out_ready=0, push pc 0 and 1 → in_ready=0 after the second push.
  - A third in_valid is not accepted.
  - Raise out_ready → pc 0 then pc 1 emerge in order, and in_ready returns to 1.
- Streaming: in_valid=out_ready=1 for 10 cycles with pc 0..9 → one output per cycle, in order, no drops, pointers wrap.
- HALT drain:
  - Push LDI (pc 3) then HALT 18'h3_C000 (pc 4) → in_ready=0 after the HALT push.
  - LDI then HALT are output with out_halt=1 on pc 4.
  - After that pop, halted=1 and out_valid=0.
  - flush=1 → halted=0, in_ready=1.
- Flush priority and illegal: queue holding 2 entries, flush=1 with in_valid=1 in the same cycle → next cycle out_valid=0, count=0. Then push opcode D → out_illegal=1, out_reg_we=0.
